regfile_dump_seq: RTL and testbench

REGFILE_DUMP_SEQ -- requirements
Module: regfile_dump_seq

---
 rtl/regfile_dump_seq_if.sv | 34 +++
 rtl/regfile_dump_seq.sv | 134 +++++++++++++
 tb/tb_regfile_dump_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_seq_if.sv
// Bus bundle between the register-file dump sequencer and its surroundings:
// dump control, pipeline halt handshake, debug register-file read port and
// the byte stream toward the UART transmitter.
//
// Byte stream handshake: tx_data is valid while tx_valid is high; a byte is
// transferred on every rising clock edge where tx_valid and tx_ready are both
// high. Once tx_valid rises, tx_data and tx_valid hold until that transfer.
interface regfile_dump_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              halt_req;
    logic              halt_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // Sequencer side
    modport master (
        input  start, halt_ack, rd_data, tx_ready,
        output busy, done, halt_req, rd_addr, tx_data, tx_valid
    );

    // Pipeline / register file / transmitter side
    modport slave (
        output start, halt_ack, rd_data, tx_ready,
        input  busy, done, halt_req, rd_addr, tx_data, tx_valid
    );
endinterface

// File: rtl/regfile_dump_seq.sv
// Register-file dump sequencer: on start, freezes the pipeline, then reads
// every register 0 .. 2**ADDR_W-1 through the debug read port and streams
// each one MSB-first as DATA_W/8 bytes toward a UART transmitter.
// Optional feature: define DUMP_HEADER_EN to prefix the stream with 0xA5.
// dbg_state exposes the FSM state encoding for observation.
module regfile_dump_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_dump_seq_if.master     bus,
    output logic [2:0]             dbg_state
);
    localparam int NB   = DATA_W / 8;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HALT = 3'd1,
`ifdef DUMP_HEADER_EN
        S_HDR  = 3'd2,
`endif
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [BC_W-1:0]   byte_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic              busy_r;
    logic              done_r;
    logic              halt_r;
    logic              valid_r;
    logic [7:0]        data_r;

    // Next byte is always taken from the top of the shift register after
    // discarding the byte just accepted.
    always_comb begin
        sh_next = shreg << 8;
    end

    // Dump sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            halt_r   <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_HALT;
                        busy_r <= 1'b1;
                        halt_r <= 1'b1;
                        idx    <= '0;
                    end
                end
                S_HALT: begin
                    if (bus.halt_ack) begin
`ifdef DUMP_HEADER_EN
                        state   <= S_HDR;
                        valid_r <= 1'b1;
                        data_r  <= 8'hA5;
`else
                        state   <= S_LOAD;
`endif
                    end
                end
`ifdef DUMP_HEADER_EN
                S_HDR: begin
                    if (bus.tx_ready) begin
                        valid_r <= 1'b0;
                        state   <= S_LOAD;
                    end
                end
`endif
                S_LOAD: begin
                    shreg    <= bus.rd_data;
                    byte_cnt <= '0;
                    valid_r  <= 1'b1;
                    data_r   <= bus.rd_data[DATA_W-1 -: 8];
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            valid_r <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state  <= S_DONE;
                                done_r <= 1'b1;
                            end else begin
                                idx   <= idx + ADDR_W'(1);
                                state <= S_LOAD;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                            shreg    <= sh_next;
                            data_r   <= sh_next[DATA_W-1 -: 8];
                        end
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    halt_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.halt_req = halt_r;
    assign bus.rd_addr  = idx;
    assign bus.tx_data  = data_r;
    assign bus.tx_valid = valid_r;
    assign dbg_state    = state;
endmodule

// File: tb/tb_regfile_dump_seq.sv
// Bench for regfile_dump_seq: random register file contents, random
// transmitter back-pressure and halt-acknowledge delays, reset mid-dump.
// The expected byte stream is derived directly from the register array.
module tb_regfile_dump_seq;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;
    localparam int NB     = DATA_W / 8;
`ifdef DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = NREG * NB + HDR;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_dump_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    logic [2:0] dbg_state;

    regfile_dump_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Register file model with combinational read
    logic [DATA_W-1:0] rf [NREG];
    assign bus.rd_data = rf[bus.rd_addr];

    // Scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int   done_cnt     = 0;
    int   stall_cycles = 0;
    bit   rand_ready   = 1'b0;
    bit   stall_b2     = 1'b0;
    int   stall_left   = 0;
    bit   prev_stall   = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected stream: optional header, then every register MSB byte first.
    task automatic load_model();
        exp_q.delete();
        got_q.delete();
        done_cnt     = 0;
        stall_cycles = 0;
        if (HDR == 1) exp_q.push_back(8'hA5);
        for (int i = 0; i < NREG; i++)
            for (int b = NB - 1; b >= 0; b--)
                exp_q.push_back(rf[i][b*8 +: 8]);
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!bus.done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_within_budget", 32'(c < budget), 32'd1);
    endtask

    // Transmitter ready driver: always ready, random, or a 10-cycle stall
    // on the third byte of the stream.
    always @(posedge clk) begin
        #1;
        if (stall_b2 && got_q.size() == 2 && stall_left > 0) begin
            bus.tx_ready = 1'b0;
            stall_left--;
        end else begin
            bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor: a handshake seen here is accepted at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid_held", 32'(bus.tx_valid), 32'd1);
                check_eq("stall_data_held", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.busy) begin
                check_eq("halt_req_while_busy", 32'(bus.halt_req), 32'd1);
            end else begin
                check_eq("halt_req_idle", 32'(bus.halt_req), 32'd0);
                check_eq("tx_valid_idle", 32'(bus.tx_valid), 32'd0);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                got_q.push_back(bus.tx_data);
                check_eq("byte_was_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check_eq("stream_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            if (bus.tx_valid && !bus.tx_ready) stall_cycles++;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (bus.done) begin
                done_cnt++;
                check_eq("done_after_last_byte", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},     32'(bus.busy),     32'd0);
        check_eq({tag, "_done"},     32'(bus.done),     32'd0);
        check_eq({tag, "_halt_req"}, 32'(bus.halt_req), 32'd0);
        check_eq({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        check_eq({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
        check_eq({tag, "_rd_addr"},  32'(bus.rd_addr),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int n_before;
        bus.start    = 1'b0;
        bus.halt_ack = 1'b1;
        bus.tx_ready = 1'b1;
        randomize_rf();

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Register 3 = 5, always ready, immediate acknowledge
        randomize_rf();
        rf[3] = 32'd5;
        load_model();
        pulse_start();
        wait_done(2000);
        repeat (3) @(negedge clk);
        check_eq("a_byte_count", 32'(got_q.size()), 32'(TOTAL));
        check_eq("a_byte12", 32'(got_q[12 + HDR]), 32'h00);
        check_eq("a_byte13", 32'(got_q[13 + HDR]), 32'h00);
        check_eq("a_byte14", 32'(got_q[14 + HDR]), 32'h00);
        check_eq("a_byte15", 32'(got_q[15 + HDR]), 32'h05);
        check_eq("a_done_once", 32'(done_cnt), 32'd1);
        if (HDR == 1) check_eq("a_header", 32'(got_q[0]), 32'hA5);

        // Ten-cycle stall on byte 2
        randomize_rf();
        load_model();
        stall_left = 10;
        stall_b2   = 1'b1;
        pulse_start();
        wait_done(2000);
        stall_b2 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("b_stall_cycles", 32'(stall_cycles), 32'd10);
        check_eq("b_byte_count", 32'(got_q.size()), 32'(TOTAL));
        check_eq("b_done_once", 32'(done_cnt), 32'd1);

        // Late acknowledge, random back-pressure, start while busy
        randomize_rf();
        load_model();
        rand_ready   = 1'b1;
        bus.halt_ack = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("c_no_valid_before_ack", 32'(bus.tx_valid), 32'd0);
            check_eq("c_halt_req_before_ack", 32'(bus.halt_req), 32'd1);
        end
        @(posedge clk); #1 bus.halt_ack = 1'b1;
        repeat ($urandom_range(20, 60)) @(posedge clk);
        #1 bus.halt_ack = 1'b0;
        pulse_start();
        wait_done(5000);
        repeat (2) @(negedge clk);
        check_eq("c_byte_count", 32'(got_q.size()), 32'(TOTAL));
        check_eq("c_done_once", 32'(done_cnt), 32'd1);

        // Start in the first IDLE cycle after DONE
        bus.halt_ack = 1'b1;
        randomize_rf();
        load_model();
        pulse_start();
        wait_done(5000);
        @(posedge clk); #1;
        check_eq("d_idle_after_done", 32'(bus.busy), 32'd0);
        randomize_rf();
        load_model();
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        check_eq("d_restart_busy", 32'(bus.busy), 32'd1);
        wait_done(5000);
        repeat (2) @(negedge clk);
        check_eq("d_byte_count", 32'(got_q.size()), 32'(TOTAL));
        check_eq("d_done_once", 32'(done_cnt), 32'd1);

        // Reset while sending register 7
        rand_ready = 1'b0;
        randomize_rf();
        load_model();
        pulse_start();
        found = 0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            @(negedge clk);
            if (bus.rd_addr == 7 && bus.tx_valid) found = 1;
        end
        check_eq("e_reached_idx7", 32'(found), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_all_zero("e_async_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_before = got_q.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("e_quiet_after_reset", 32'(bus.tx_valid), 32'd0);
        end
        check_eq("e_no_bytes_after_reset", 32'(got_q.size()), 32'(n_before));
        randomize_rf();
        load_model();
        pulse_start();
        wait_done(2000);
        repeat (2) @(negedge clk);
        check_eq("e_byte_count", 32'(got_q.size()), 32'(TOTAL));
        check_eq("e_first_byte", 32'(got_q[0]), HDR == 1 ? 32'hA5 : 32'(rf[0][DATA_W-1 -: 8]));
        check_eq("e_done_once", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
